// File: rtl/sample_discriminator_core.sv
// Per-channel ADC sample gate: hysteresis or delayed digital trigger, pre-trigger
// delay line, post-trigger hold and run-start timestamps carrying the word index.
module sample_discriminator_core #(
  parameter int CHANNELS         = 2,
  parameter int TX_CHANNELS      = 2,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 4,
  parameter int MAX_DELAY_CYCLES = 64,
  parameter int TSTAMP_WIDTH     = 48,
  localparam int DATA_WIDTH = SAMPLE_WIDTH * PARALLEL_SAMPLES,
  localparam int TIMER_BITS = $clog2(MAX_DELAY_CYCLES),
  localparam int SEL_BITS   = $clog2(CHANNELS + TX_CHANNELS)
) (
  input  logic                               adc_clk,
  input  logic                               adc_reset_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0]     adc_data_in_data,
  input  logic [CHANNELS-1:0]                adc_data_in_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0]     adc_data_out_data,
  output logic [CHANNELS-1:0]                adc_data_out_valid,
  output logic [CHANNELS*TSTAMP_WIDTH-1:0]   adc_timestamps_out_data,
  output logic [CHANNELS-1:0]                adc_timestamps_out_valid,
  input  logic                               adc_reset_state,
  input  logic [TX_CHANNELS-1:0]             adc_digital_trigger_in,
  input  logic [2*CHANNELS*SAMPLE_WIDTH-1:0] thresholds_data,
  input  logic                               thresholds_valid,
  output logic                               thresholds_ready,
  input  logic [3*CHANNELS*TIMER_BITS-1:0]   delays_data,
  input  logic                               delays_valid,
  output logic                               delays_ready,
  input  logic [CHANNELS*SEL_BITS-1:0]       trigger_select_data,
  input  logic                               trigger_select_valid,
  output logic                               trigger_select_ready,
  input  logic [CHANNELS-1:0]                disable_data,
  input  logic                               disable_valid,
  output logic                               disable_ready
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic                    valid;
    logic [TSTAMP_WIDTH-1:0] idx;
  } slot_t;

  function automatic logic [CHANNELS*SEL_BITS-1:0] sel_default();
    logic [CHANNELS*SEL_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++) r[i*SEL_BITS +: SEL_BITS] = SEL_BITS'(i);
    return r;
  endfunction

  logic [2*CHANNELS*SAMPLE_WIDTH-1:0] thr_q;
  logic [3*CHANNELS*TIMER_BITS-1:0]   dly_q;
  logic [CHANNELS*SEL_BITS-1:0]       sel_q;
  logic [CHANNELS-1:0]                dis_q;
  logic [MAX_DELAY_CYCLES-1:0]        dig_sr_q [TX_CHANNELS];
  logic [CHANNELS-1:0]                ana_trig;

  // Config streams: ready is tied high; a valid beat loads the whole register and
  // takes effect on the following cycle.
  assign thresholds_ready     = 1'b1;
  assign delays_ready         = 1'b1;
  assign trigger_select_ready = 1'b1;
  assign disable_ready        = 1'b1;

  always_ff @(posedge adc_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) begin
      thr_q <= '0;
      dly_q <= '0;
      sel_q <= sel_default();
      dis_q <= '1;
    end else begin
      if (thresholds_valid)     thr_q <= thresholds_data;
      if (delays_valid)         dly_q <= delays_data;
      if (trigger_select_valid) sel_q <= trigger_select_data;
      if (disable_valid)        dis_q <= disable_data;
    end
  end

  // Bit 0 is the line registered once; bit g is that value g cycles older.
  always_ff @(posedge adc_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) begin
      for (int l = 0; l < TX_CHANNELS; l++) dig_sr_q[l] <= '0;
    end else if (adc_reset_state) begin
      for (int l = 0; l < TX_CHANNELS; l++)
        dig_sr_q[l] <= {{(MAX_DELAY_CYCLES-1){1'b0}}, adc_digital_trigger_in[l]};
    end else begin
      for (int l = 0; l < TX_CHANNELS; l++)
        dig_sr_q[l] <= {dig_sr_q[l][MAX_DELAY_CYCLES-2:0], adc_digital_trigger_in[l]};
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DATA_WIDTH-1:0]          word;
    logic                           in_valid;
    logic signed [SAMPLE_WIDTH-1:0] thr_lo, thr_hi;
    logic [TIMER_BITS-1:0]          s_dly, p_dly, g_dly;
    logic [SEL_BITS-1:0]            sel;
    logic                           any_hi, all_lo, t_prev, t_d, t_q;
    logic [TSTAMP_WIDTH-1:0]        cnt_q, idx_cur;
    slot_t                          in_slot, tap;
    slot_t                          dl_q [MAX_DELAY_CYCLES];
    logic                           trig, gate;
    logic [TIMER_BITS-1:0]          hold_q, hold_d;
    logic                           out_valid_d, out_valid_q, prev_q, ts_valid_q;
    logic [DATA_WIDTH-1:0]          out_data_q;
    logic [TSTAMP_WIDTH-1:0]        ts_data_q;

    assign word     = adc_data_in_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign in_valid = adc_data_in_valid[i];
    assign thr_lo   = thr_q[2*i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign thr_hi   = thr_q[(2*i+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign s_dly    = dly_q[3*i*TIMER_BITS +: TIMER_BITS];
    assign p_dly    = dly_q[(3*i+1)*TIMER_BITS +: TIMER_BITS];
    assign g_dly    = dly_q[(3*i+2)*TIMER_BITS +: TIMER_BITS];
    assign sel      = sel_q[i*SEL_BITS +: SEL_BITS];

    always_comb begin
      any_hi = 1'b0;
      all_lo = 1'b1;
      for (int k = 0; k < PARALLEL_SAMPLES; k++) begin
        if ($signed(word[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > thr_hi)  any_hi = 1'b1;
        if ($signed(word[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]) >= thr_lo) all_lo = 1'b0;
      end
    end

    // A word arriving with reset_state sees cleared hysteresis and gets index 0.
    assign t_prev  = adc_reset_state ? 1'b0 : t_q;
    assign idx_cur = adc_reset_state ? '0 : cnt_q;

    always_comb begin
      t_d = t_prev;
      if (in_valid) begin
        if (any_hi)      t_d = 1'b1;
        else if (all_lo) t_d = 1'b0;
      end
    end

    assign ana_trig[i] = t_q;

    always_comb begin
      trig = 1'b0;
      for (int s = 0; s < CHANNELS; s++)
        if (int'(sel) == s) trig = ana_trig[s];
      for (int l = 0; l < TX_CHANNELS; l++)
        if (int'(sel) == CHANNELS + l) trig = dig_sr_q[l][g_dly];
    end

    assign gate = trig || (hold_q != '0);

    always_comb begin
      hold_d = hold_q;
      if (trig)                hold_d = p_dly;
      else if (hold_q != '0)   hold_d = hold_q - 1'b1;
    end

    assign in_slot.data  = word;
    assign in_slot.valid = in_valid;
    assign in_slot.idx   = idx_cur;

    // dl_q[0] is the input register; the tap at S pairs word n with gate G(n+S).
    assign tap         = dl_q[s_dly];
    assign out_valid_d = tap.valid && (dis_q[i] || gate);

    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
      if (!adc_reset_n) begin
        t_q         <= 1'b0;
        cnt_q       <= '0;
        hold_q      <= '0;
        prev_q      <= 1'b0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        ts_valid_q  <= 1'b0;
        ts_data_q   <= '0;
        for (int j = 0; j < MAX_DELAY_CYCLES; j++) dl_q[j] <= '0;
      end else begin
        t_q   <= t_d;
        cnt_q <= in_valid ? idx_cur + 1'b1 : idx_cur;
        dl_q[0] <= in_slot;
        for (int j = 1; j < MAX_DELAY_CYCLES; j++) begin
          if (adc_reset_state) dl_q[j] <= '0;
          else                 dl_q[j] <= dl_q[j-1];
        end
        out_valid_q <= out_valid_d;
        out_data_q  <= tap.data;
        ts_valid_q  <= out_valid_d && !dis_q[i] && !prev_q;
        ts_data_q   <= tap.idx;
        if (adc_reset_state) begin
          hold_q <= '0;
          prev_q <= 1'b0;
        end else begin
          hold_q <= hold_d;
          if (tap.valid) prev_q <= out_valid_d;
        end
      end
    end

    assign adc_data_out_data[i*DATA_WIDTH +: DATA_WIDTH]           = out_data_q;
    assign adc_data_out_valid[i]                                   = out_valid_q;
    assign adc_timestamps_out_data[i*TSTAMP_WIDTH +: TSTAMP_WIDTH] = ts_data_q;
    assign adc_timestamps_out_valid[i]                             = ts_valid_q;
  end

endmodule

// File: tb/tb_sample_discriminator_core.sv
// Directed bench for sample_discriminator_core: records channel 0 outputs and
// compares them with hand-derived word ranges, indices and latencies.
module tb_sample_discriminator_core;
  localparam int CH = 2, TX = 2, SW = 16, PS = 4, DW = 64, TB = 6, TSW = 48, SB = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [CH*DW-1:0]     in_data;
  logic [CH-1:0]        in_valid;
  logic [CH*DW-1:0]     out_data;
  logic [CH-1:0]        out_valid;
  logic [CH*TSW-1:0]    ts_data;
  logic [CH-1:0]        ts_valid;
  logic                 reset_state;
  logic [TX-1:0]        dig_in;
  logic [2*CH*SW-1:0]   thr_data;
  logic                 thr_valid, thr_ready;
  logic [3*CH*TB-1:0]   dly_data;
  logic                 dly_valid, dly_ready;
  logic [CH*SB-1:0]     sel_data;
  logic                 sel_valid, sel_ready;
  logic [CH-1:0]        dis_data;
  logic                 dis_valid, dis_ready;

  sample_discriminator_core dut (
    .adc_clk(clk), .adc_reset_n(rst_n),
    .adc_data_in_data(in_data), .adc_data_in_valid(in_valid),
    .adc_data_out_data(out_data), .adc_data_out_valid(out_valid),
    .adc_timestamps_out_data(ts_data), .adc_timestamps_out_valid(ts_valid),
    .adc_reset_state(reset_state), .adc_digital_trigger_in(dig_in),
    .thresholds_data(thr_data), .thresholds_valid(thr_valid), .thresholds_ready(thr_ready),
    .delays_data(dly_data), .delays_valid(dly_valid), .delays_ready(dly_ready),
    .trigger_select_data(sel_data), .trigger_select_valid(sel_valid),
    .trigger_select_ready(sel_ready),
    .disable_data(dis_data), .disable_valid(dis_valid), .disable_ready(dis_ready)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  logic [DW-1:0]  obs_q[$];
  int             obs_cyc_q[$];
  logic [TSW-1:0] obs_ts_q[$];
  int             obs_ts_cyc_q[$];
  int             ch1_n = 0, ch1_ts_n = 0;

  logic [DW-1:0]  exp_q[$];
  int             exp_cyc_q[$];
  logic [TSW-1:0] exp_ts_q[$];
  int             exp_ts_cyc_q[$];

  int stim_v_q[$];
  bit stim_val_q[$], stim_dig_q[$], stim_rs_q[$];
  int stim_cyc_q[$];

  localparam logic [2*CH*SW-1:0] THR = {16'd0, 16'd0, 16'd16, 16'd8};

  // output monitor
  always @(negedge clk) begin
    if (out_valid[0]) begin
      obs_q.push_back(out_data[DW-1:0]);
      obs_cyc_q.push_back(cyc);
    end
    if (ts_valid[0]) begin
      obs_ts_q.push_back(ts_data[TSW-1:0]);
      obs_ts_cyc_q.push_back(cyc);
    end
    if (out_valid[1]) ch1_n++;
    if (ts_valid[1])  ch1_ts_n++;
  end

  function automatic logic [DW-1:0] rep(input int v);
    logic [SW-1:0] s;
    s = v[SW-1:0];
    return {PS{s}};
  endfunction

  function automatic logic [3*CH*TB-1:0] dly(input int s, input int p, input int g);
    logic [3*CH*TB-1:0] r;
    r = '0;
    r[5:0]   = 6'(s);
    r[11:6]  = 6'(p);
    r[17:12] = 6'(g);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic configure(input logic [2*CH*SW-1:0] thr, input logic [3*CH*TB-1:0] d,
                           input logic [CH*SB-1:0] sel, input logic [CH-1:0] dis);
    @(posedge clk); #1;
    thr_data = thr; dly_data = d; sel_data = sel; dis_data = dis;
    thr_valid = 1'b1; dly_valid = 1'b1; sel_valid = 1'b1; dis_valid = 1'b1;
    @(posedge clk); #1;
    thr_valid = 1'b0; dly_valid = 1'b0; sel_valid = 1'b0; dis_valid = 1'b0;
    reset_state = 1'b1;
    @(posedge clk); #1;
    reset_state = 1'b0;
  endtask

  task automatic stim_clear();
    stim_v_q.delete(); stim_val_q.delete(); stim_dig_q.delete(); stim_rs_q.delete();
    stim_cyc_q.delete();
  endtask

  task automatic step(input int v, input bit val, input bit dg, input bit rs);
    stim_v_q.push_back(v); stim_val_q.push_back(val);
    stim_dig_q.push_back(dg); stim_rs_q.push_back(rs);
  endtask

  task automatic ramp(input int from, input int to);
    if (from <= to) for (int v = from; v <= to; v++) step(v, 1'b1, 1'b0, 1'b0);
    else            for (int v = from; v >= to; v--) step(v, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic play();
    obs_q.delete(); obs_cyc_q.delete(); obs_ts_q.delete(); obs_ts_cyc_q.delete();
    ch1_n = 0; ch1_ts_n = 0;
    for (int s = 0; s < stim_v_q.size(); s++) begin
      @(posedge clk); #1;
      in_data     = {rep(stim_v_q[s]), rep(stim_v_q[s])};
      in_valid    = {2{stim_val_q[s]}};
      dig_in      = {1'b0, stim_dig_q[s]};
      reset_state = stim_rs_q[s];
      stim_cyc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    in_data = '0; in_valid = '0; dig_in = '0; reset_state = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  // scoreboard
  task automatic exp_clear();
    exp_q.delete(); exp_cyc_q.delete(); exp_ts_q.delete(); exp_ts_cyc_q.delete();
  endtask

  task automatic exp_word(input int s, input int lat);
    exp_q.push_back(rep(stim_v_q[s]));
    exp_cyc_q.push_back(stim_cyc_q[s] + lat);
  endtask

  task automatic exp_ts(input int s, input int idx, input int lat);
    exp_ts_q.push_back(TSW'(idx));
    exp_ts_cyc_q.push_back(stim_cyc_q[s] + lat);
  endtask

  task automatic check_run(input string tag);
    chk({tag, " word count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++) begin
      if (j < obs_q.size()) begin
        chk({tag, " word data"}, obs_q[j], exp_q[j]);
        chk({tag, " word cycle"}, 64'(obs_cyc_q[j]), 64'(exp_cyc_q[j]));
      end
    end
    chk({tag, " ts count"}, 64'(obs_ts_q.size()), 64'(exp_ts_q.size()));
    for (int j = 0; j < exp_ts_q.size(); j++) begin
      if (j < obs_ts_q.size()) begin
        chk({tag, " ts index"}, 64'(obs_ts_q[j]), 64'(exp_ts_q[j]));
        chk({tag, " ts cycle"}, 64'(obs_ts_cyc_q[j]), 64'(exp_ts_cyc_q[j]));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; reset_state = 1'b0; dig_in = '0;
    thr_data = '0; thr_valid = 1'b0; dly_data = '0; dly_valid = 1'b0;
    sel_data = '0; sel_valid = 1'b0; dis_data = '0; dis_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", 64'(out_data[DW-1:0]), 64'd0);
    chk("reset ts_valid", 64'(ts_valid), 64'd0);
    chk("reset readies", 64'({thr_ready, dly_ready, sel_ready, dis_ready}), 64'hf);

    // defaults: pass-through, latency 2, no timestamps
    stim_clear(); ramp(0, 24); play();
    exp_clear();
    for (int s = 0; s <= 24; s++) exp_word(s, 2);
    check_run("default");
    chk("default ch1 count", 64'(ch1_n), 64'd25);
    chk("default ch1 ts", 64'(ch1_ts_n), 64'd0);

    // hysteresis, S=P=0: run from value 17 up through value 8 on the way down
    configure(THR, dly(0, 0, 0), {2'd1, 2'd0}, 2'b10);
    stim_clear(); ramp(0, 24); ramp(24, 0); play();
    exp_clear();
    for (int s = 17; s <= 41; s++) exp_word(s, 2);
    exp_ts(17, 17, 2);
    check_run("hyst");

    // S=3: run moves 3 words earlier, latency 5
    configure(THR, dly(3, 0, 0), {2'd1, 2'd0}, 2'b10);
    stim_clear(); ramp(0, 24); ramp(24, 0); play();
    exp_clear();
    for (int s = 14; s <= 38; s++) exp_word(s, 5);
    exp_ts(14, 14, 5);
    check_run("pretrig");

    // P=4 single spike: 5 words
    configure(THR, dly(0, 4, 0), {2'd1, 2'd0}, 2'b10);
    stim_clear();
    for (int s = 0; s < 5; s++) step(0, 1'b1, 1'b0, 1'b0);
    step(20, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 10; s++) step(0, 1'b1, 1'b0, 1'b0);
    play();
    exp_clear();
    for (int s = 5; s <= 9; s++) exp_word(s, 2);
    exp_ts(5, 5, 2);
    check_run("hold");

    // digital line 0, G=2, pulse at word 10 gates word 12
    configure(THR, dly(0, 0, 2), {2'd1, 2'd2}, 2'b10);
    stim_clear();
    for (int v = 0; v <= 24; v++) step(v, 1'b1, v == 10, 1'b0);
    play();
    exp_clear();
    exp_word(12, 2);
    exp_ts(12, 12, 2);
    check_run("digital");

    // reset_state between two runs: second run indices restart at 0
    configure(THR, dly(0, 0, 0), {2'd1, 2'd0}, 2'b10);
    stim_clear(); ramp(0, 24); step(0, 1'b0, 1'b0, 1'b1); ramp(24, 0); play();
    exp_clear();
    for (int s = 17; s <= 24; s++) exp_word(s, 2);
    for (int s = 26; s <= 42; s++) exp_word(s, 2);
    exp_ts(17, 17, 2);
    exp_ts(26, 0, 2);
    check_run("rst_state");

    // async reset mid-stream
    for (int v = 1; v <= 6; v++) begin
      @(posedge clk); #1;
      in_data = {rep(v), rep(v)}; in_valid = 2'b11;
    end
    @(posedge clk); #1;
    chk("pre-reset ch1 valid", 64'(out_valid[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async out_data ch0", 64'(out_data[DW-1:0]), 64'd0);
    chk("async out_data ch1", 64'(out_data[2*DW-1:DW]), 64'd0);
    chk("async ts_valid", 64'(ts_valid), 64'd0);
    chk("async ts_data", 64'(ts_data[TSW-1:0]), 64'd0);
    in_data = '0; in_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // config back at defaults: everything passes again with latency 2
    stim_clear(); ramp(0, 9); play();
    exp_clear();
    for (int s = 0; s <= 9; s++) exp_word(s, 2);
    check_run("post-reset");
    chk("post-reset ch1 count", 64'(ch1_n), 64'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
